cache_assoc_controller: RTL and testbench

- Next-generation controller for the write-back data cache, generalised from direct-mapped to NUM_WAYS-way set-associative.
- Fixed-latency memory timing replaced by a per-word valid/ready memory handshake.
- Sits between the processor load/store port and the set/line storage.
- Drives line-array control, victim selection and main-memory transfers; stalls the processor on miss.

---
 rtl/cache_assoc_controller_pkg.sv | 49 ++++
 rtl/cache_assoc_controller_if.sv | 10 +
 rtl/cache_assoc_controller_plru_table.sv | 37 +++
 rtl/cache_assoc_controller.sv | 188 ++++++++++++++++++
 tb/tb_cache_assoc_controller.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_assoc_controller_pkg.sv
// Shared types, default geometry and tree-PLRU helpers for the set-associative cache controller.
package cache_assoc_pkg;
    localparam int STATE_WIDTH      = 2;
    localparam int TAG_WIDTH_DEF    = 20;
    localparam int SET_WIDTH_DEF    = 7;
    localparam int OFFSET_WIDTH_DEF = 5;
    localparam int NUM_WAYS_DEF     = 4;
    localparam int PLRU_MAX_BITS    = 7;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        REFILL     = 2'd2,
        REPLAY     = 2'd3
    } state_e;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit points the victim left.
    function automatic logic [2:0] plru_victim(input logic [PLRU_MAX_BITS-1:0] tree, input int levels);
        logic [2:0] node;
        logic [2:0] way;
        node = '0;
        way  = '0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                way  = {way[1:0], tree[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, tree[node]};
            end
        end
        return way;
    endfunction

    function automatic logic [PLRU_MAX_BITS-1:0] plru_update(input logic [PLRU_MAX_BITS-1:0] tree,
                                                             input logic [2:0] way, input int levels);
        logic [PLRU_MAX_BITS-1:0] t;
        logic [2:0] node;
        logic [2:0] w;
        t    = tree;
        node = '0;
        w    = way << (3 - levels);
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                t[node] = ~w[2];
                node    = {node[1:0], 1'b0} + 3'd1 + {2'b00, w[2]};
                w       = {w[1:0], 1'b0};
            end
        end
        return t;
    endfunction
endpackage

// File: rtl/cache_assoc_controller_if.sv
// Word-beat memory handshake between the cache controller (master) and main memory (slave).
interface cache_assoc_controller_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ready;

    modport master (output mem_req, mem_we, mem_addr, input mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, output mem_ready);
endinterface

// File: rtl/cache_assoc_controller_plru_table.sv
// Per-set tree-PLRU bits: synchronous update, combinational victim read. Absent when NUM_WAYS=1.
module cache_plru_table
    import cache_assoc_pkg::*;
#(
    parameter int SET_WIDTH = SET_WIDTH_DEF,
    parameter int NUM_WAYS  = NUM_WAYS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SET_WIDTH-1:0] set_i,
    input  logic                 upd_en_i,
    input  logic [2:0]           upd_way_i,
    output logic [2:0]           victim_o
);
    localparam int LEVELS = $clog2(NUM_WAYS);

    generate
        if (NUM_WAYS > 1) begin : g_plru
            localparam int TB = NUM_WAYS - 1;
            logic [TB-1:0]            tree_q [2**SET_WIDTH];
            logic [PLRU_MAX_BITS-1:0] tree_rd;

            assign tree_rd  = PLRU_MAX_BITS'(tree_q[set_i]);
            assign victim_o = plru_victim(tree_rd, LEVELS);

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int s = 0; s < 2**SET_WIDTH; s++) tree_q[s] <= '0;
                end else if (upd_en_i) begin
                    tree_q[set_i] <= TB'(plru_update(tree_rd, upd_way_i, LEVELS));
                end
            end
        end else begin : g_direct
            assign victim_o = '0;
        end
    endgenerate
endmodule

// File: rtl/cache_assoc_controller.sv
// Write-back set-associative cache controller with per-word memory handshake.
// Optional hit/miss/write-back counters are built when CACHE_PERF_COUNTERS_EN is defined.
module cache_assoc_controller
    import cache_assoc_pkg::*;
#(
    parameter int TAG_WIDTH    = TAG_WIDTH_DEF,
    parameter int SET_WIDTH    = SET_WIDTH_DEF,
    parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
    parameter int NUM_WAYS     = NUM_WAYS_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    write_en_i,
    input  logic [31:0]             addr_i,
    input  logic [NUM_WAYS-1:0]     hit_way_i,
    input  logic [NUM_WAYS-1:0]     dirty_way_i,
    input  logic [NUM_WAYS-1:0]     valid_way_i,
    input  logic [TAG_WIDTH-1:0]    victim_tag_i,
    output logic [NUM_WAYS-1:0]     way_sel_o,
    output logic                    line_write_en_o,
    output logic                    set_valid_o,
    output logic                    set_dirty_o,
    output logic [OFFSET_WIDTH-3:0] offset_line_o,
    output logic                    offset_sel_o,
    output logic                    stall_o,
    cache_assoc_controller_if.master mem,
    output logic [STATE_WIDTH-1:0]  state_o
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o,
    output logic [31:0]             wb_count_o
`endif
);
    localparam int LW = OFFSET_WIDTH - 2;

    state_e               state_q, state_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [NUM_WAYS-1:0]  victim_q, victim_d;
    logic [SET_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0] tag;
    logic [NUM_WAYS-1:0]  hit_oh, inv_oh, victim_oh;
    logic [2:0]           hit_idx, plru_idx;
    logic                 plru_upd;
    logic                 unused_addr;

    assign index       = addr_i[OFFSET_WIDTH +: SET_WIDTH];
    assign tag         = addr_i[OFFSET_WIDTH+SET_WIDTH +: TAG_WIDTH];
    assign unused_addr = ^addr_i[OFFSET_WIDTH-1:0];

    // Lowest set bit of hit vector, lowest clear bit of valid vector.
    assign hit_oh    = hit_way_i & (~hit_way_i + NUM_WAYS'(1));
    assign inv_oh    = ~valid_way_i & (valid_way_i + NUM_WAYS'(1));
    assign victim_oh = (&valid_way_i) ? (NUM_WAYS'(1) << plru_idx) : inv_oh;

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_way_i[i]) hit_idx = 3'(i);
        end
    end

    cache_plru_table #(.SET_WIDTH(SET_WIDTH), .NUM_WAYS(NUM_WAYS)) u_plru (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .set_i     (index),
        .upd_en_i  (plru_upd),
        .upd_way_i (hit_idx),
        .victim_o  (plru_idx)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
        end
    end

    // Outputs are forced idle while reset is asserted so an aborted transfer issues no beat.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        victim_d        = victim_q;
        way_sel_o       = '0;
        line_write_en_o = 1'b0;
        set_valid_o     = 1'b0;
        set_dirty_o     = 1'b0;
        offset_line_o   = '0;
        offset_sel_o    = 1'b1;
        stall_o         = 1'b0;
        mem.mem_req     = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_addr    = '0;
        plru_upd        = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (en_i) begin
                        if (|hit_way_i) begin
                            way_sel_o = hit_oh;
                            plru_upd  = 1'b1;
                            if (write_en_i) begin
                                line_write_en_o = 1'b1;
                                set_valid_o     = 1'b1;
                                set_dirty_o     = 1'b1;
                            end
                        end else begin
                            stall_o  = 1'b1;
                            victim_d = victim_oh;
                            cnt_d    = '0;
                            state_d  = (|(victim_oh & dirty_way_i)) ? WRITE_BACK : REFILL;
                        end
                    end
                end
                WRITE_BACK: begin
                    way_sel_o     = victim_q;
                    stall_o       = 1'b1;
                    offset_sel_o  = 1'b0;
                    offset_line_o = cnt_q;
                    mem.mem_req   = 1'b1;
                    mem.mem_we    = 1'b1;
                    mem.mem_addr  = 32'({victim_tag_i, index, cnt_q, 2'b00});
                    if (mem.mem_ready) begin
                        cnt_d = cnt_q + LW'(1);
                        if (&cnt_q) state_d = REFILL;
                    end
                end
                REFILL: begin
                    way_sel_o     = victim_q;
                    stall_o       = 1'b1;
                    offset_sel_o  = 1'b0;
                    offset_line_o = cnt_q;
                    mem.mem_req   = 1'b1;
                    mem.mem_addr  = 32'({tag, index, cnt_q, 2'b00});
                    if (mem.mem_ready) begin
                        line_write_en_o = 1'b1;
                        cnt_d           = cnt_q + LW'(1);
                        if (&cnt_q) begin
                            set_valid_o = 1'b1;
                            state_d     = REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    way_sel_o = victim_q;
                    stall_o   = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign state_o = state_q;

`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        replay_q;

    // replay_q marks the re-lookup cycle right after REPLAY, which is not a new hit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
            replay_q   <= 1'b0;
        end else begin
            replay_q <= (state_q == REPLAY);
            if (state_q == IDLE && en_i && (|hit_way_i) && !replay_q && !(&hit_cnt_q))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d != IDLE && !(&miss_cnt_q))
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == IDLE && state_d == WRITE_BACK && !(&wb_cnt_q))
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign wb_count_o   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_cache_assoc_controller.sv
// Self-checking bench for cache_assoc_controller: vector table for IDLE lookups plus miss/PLRU/reset sequences.
`timescale 1ns/1ps
module tb_cache_assoc_controller;
    localparam int LS = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
    } beat_t;

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] a;
        logic [3:0]  hit;
        logic [3:0]  vld;
        logic [3:0]  drt;
        logic [3:0]  e_way;
        logic        e_lwe;
        logic        e_sv;
        logic        e_sd;
        logic        e_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  hit = '0;
    logic [3:0]  dirty = '0;
    logic [3:0]  valid = '0;
    logic [19:0] vtag;
    logic [3:0]  way_sel;
    logic        lwe, sv, sd, osel, stall;
    logic [2:0]  oline;
    logic [1:0]  state;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hc, mc, wc;
`endif

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    vec_t  vt[6];

    cache_assoc_controller_if mif();

    always #5 clk = ~clk;

    // Line-array model: the tag of a way is 0x5A000 with the way's one-hot pattern in its low bits.
    assign vtag = 20'h5A000 | {16'h0, way_sel};

    cache_assoc_controller dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_i            (en),
        .write_en_i      (we),
        .addr_i          (addr),
        .hit_way_i       (hit),
        .dirty_way_i     (dirty),
        .valid_way_i     (valid),
        .victim_tag_i    (vtag),
        .way_sel_o       (way_sel),
        .line_write_en_o (lwe),
        .set_valid_o     (sv),
        .set_dirty_o     (sd),
        .offset_line_o   (oline),
        .offset_sel_o    (osel),
        .stall_o         (stall),
        .mem             (mif),
        .state_o         (state)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count_o     (hc),
        .miss_count_o    (mc),
        .wb_count_o      (wc)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [19:0] t, input logic [6:0] s);
        return {t, s, 5'b0};
    endfunction

    // Memory-side scoreboard: every accepted beat must match the next expected one.
    logic        pend = 1'b0;
    logic [31:0] pend_a = '0;
    always @(negedge clk) begin : mon
        beat_t b;
        if (mif.mem_req && pend) chk("addr_stable", 64'(mif.mem_addr), 64'(pend_a));
        if (mif.mem_req && mif.mem_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got addr 0x%0h with no beat expected", mif.mem_addr);
            end else begin
                b = exp_q.pop_front();
                chk("beat_addr", 64'(mif.mem_addr), 64'(b.a));
                chk("beat_we", 64'(mif.mem_we), 64'(b.we));
            end
        end
        pend   = mif.mem_req && !mif.mem_ready;
        pend_a = mif.mem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input logic [31:0] a, input int w);
        en = 1'b1; we = 1'b0; addr = a; hit = 4'(1 << w); valid = 4'hF; dirty = 4'h0;
        @(negedge clk);
        chk($sformatf("hit_w%0d_stall", w), 64'(stall), 64'(0));
        tick();
        en = 1'b0; hit = '0;
    endtask

    task automatic run_miss(input string nm, input logic [31:0] a, input logic [3:0] vld,
                            input logic [3:0] drt, input int vic, input bit toggle, output int stall_cyc);
        int    cyc, lwe_n, sv_n;
        bit    done;
        beat_t b;
        if (drt[vic]) begin
            for (int i = 0; i < LS; i++) begin
                b.we = 1'b1;
                b.a  = {20'h5A000 | 20'(1 << vic), a[11:5], 3'(i), 2'b00};
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < LS; i++) begin
            b.we = 1'b0;
            b.a  = {a[31:12], a[11:5], 3'(i), 2'b00};
            exp_q.push_back(b);
        end
        en = 1'b1; we = 1'b0; addr = a; hit = '0; valid = vld; dirty = drt;
        cyc = 0; lwe_n = 0; sv_n = 0; done = 1'b0; stall_cyc = 0;
        while (!done && cyc < 200) begin
            mif.mem_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (stall) stall_cyc++;
            if (lwe) lwe_n++;
            if (sv) begin
                sv_n++;
                chk({nm, "_sv_clean"}, 64'(sd), 64'(0));
            end
            if (state == 2'd3) begin
                chk({nm, "_replay_way"}, 64'(way_sel), 64'(4'(1 << vic)));
                chk({nm, "_replay_osel"}, 64'(osel), 64'(1));
                done = 1'b1;
            end
            tick();
            cyc++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no REPLAY within %0d cycles", nm, cyc);
        end
        mif.mem_ready = 1'b0;
        hit   = 4'(1 << vic);
        valid = valid | 4'(1 << vic);
        @(negedge clk);
        chk({nm, "_relookup_stall"}, 64'(stall), 64'(0));
        chk({nm, "_relookup_way"}, 64'(way_sel), 64'(4'(1 << vic)));
        chk({nm, "_relookup_state"}, 64'(state), 64'(0));
        chk({nm, "_line_writes"}, 64'(lwe_n), 64'(LS));
        chk({nm, "_set_valid_pulses"}, 64'(sv_n), 64'(1));
        chk({nm, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        tick();
        en = 1'b0; hit = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        //         en    we    addr                   hit    vld    drt    way    lwe   sv    sd    stall
        vt[0] = '{1'b0, 1'b0, mk(20'h00001, 7'd1),  4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, mk(20'h00010, 7'd10), 4'h2, 4'hF, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, mk(20'h00020, 7'd20), 4'h4, 4'hF, 4'h0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, mk(20'h00011, 7'd11), 4'h8, 4'h8, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, mk(20'h00012, 7'd12), 4'h6, 4'hF, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b1, mk(20'h00013, 7'd13), 4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};

        mif.mem_ready = 1'b0;
        en = 1'b1; hit = 4'h1; valid = 4'h1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_way_sel", 64'(way_sel), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_osel", 64'(osel), 64'(1));
        tick();
        rst_n = 1'b1; en = 1'b0; hit = '0; valid = '0;

        for (int i = 0; i < 6; i++) begin
            en = vt[i].en; we = vt[i].we; addr = vt[i].a;
            hit = vt[i].hit; valid = vt[i].vld; dirty = vt[i].drt;
            @(negedge clk);
            chk($sformatf("vec%0d_way", i), 64'(way_sel), 64'(vt[i].e_way));
            chk($sformatf("vec%0d_lwe", i), 64'(lwe), 64'(vt[i].e_lwe));
            chk($sformatf("vec%0d_sv", i), 64'(sv), 64'(vt[i].e_sv));
            chk($sformatf("vec%0d_sd", i), 64'(sd), 64'(vt[i].e_sd));
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vt[i].e_stall));
            chk($sformatf("vec%0d_osel", i), 64'(osel), 64'(1));
            chk($sformatf("vec%0d_req", i), 64'(mif.mem_req), 64'(0));
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(0));
            tick();
        end
        en = 1'b0; we = 1'b0; hit = '0;

        // Way 2 was just stored to in set 20, so the PLRU must not pick it.
        run_miss("after_store", mk(20'h00021, 7'd20), 4'hF, 4'h0, 0, 1'b0, sc);

        run_miss("cold", mk(20'hC0FFE, 7'd30), 4'h0, 4'h0, 0, 1'b0, sc);
        chk("cold_stall_cycles", 64'(sc), 64'(10));

        for (int w = 0; w < 4; w++) do_hit(mk(20'h00040, 7'd40), w);
        run_miss("plru_v0", mk(20'h00041, 7'd40), 4'hF, 4'hE, 0, 1'b0, sc);
        chk("plru_v0_stall_cycles", 64'(sc), 64'(10));
        run_miss("plru_v2_wb", mk(20'h00042, 7'd40), 4'hF, 4'h4, 2, 1'b1, sc);
        do_hit(mk(20'h00040, 7'd40), 1);

        // Abort a refill on its fourth beat.
        begin
            beat_t b;
            for (int i = 0; i < LS; i++) begin
                b.we = 1'b0;
                b.a  = {20'h77777, 7'd50, 3'(i), 2'b00};
                exp_q.push_back(b);
            end
        end
        en = 1'b1; we = 1'b0; addr = mk(20'h77777, 7'd50); hit = '0; valid = '0; dirty = '0;
        mif.mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_test_miss_stall", 64'(stall), 64'(1));
        tick();
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_abort_req", 64'(mif.mem_req), 64'(0));
        tick();
        rst_n = 1'b1; en = 1'b0; mif.mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_after_state", 64'(state), 64'(0));
        chk("rst_after_req", 64'(mif.mem_req), 64'(0));
        chk("rst_unissued_beats", 64'(exp_q.size()), 64'(5));
        exp_q.delete();
        tick();

        // Before reset set 40 pointed at way 3; a cleared tree points at way 0.
        run_miss("post_rst", mk(20'h00043, 7'd40), 4'hF, 4'h0, 0, 1'b0, sc);

`ifdef CACHE_PERF_COUNTERS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("perf_rst_hits", 64'(hc), 64'(0));
        tick();
        for (int k = 0; k < 5; k++) do_hit(mk(20'h00060, 7'd60), k % 4);
        run_miss("perf_c1", mk(20'h00061, 7'd61), 4'h0, 4'h0, 0, 1'b0, sc);
        run_miss("perf_c2", mk(20'h00062, 7'd62), 4'h0, 4'h0, 0, 1'b0, sc);
        run_miss("perf_d1", mk(20'h00063, 7'd63), 4'hF, 4'h1, 0, 1'b0, sc);
        @(negedge clk);
        chk("perf_hits", 64'(hc), 64'(5));
        chk("perf_misses", 64'(mc), 64'(3));
        chk("perf_wbs", 64'(wc), 64'(1));
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
